// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared MEM-stage definitions (FSM states, alignment mask, default bus timeout)
package mem_access_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;
    localparam logic [31:0] ALIGN_MASK  = 32'h0000_0003;
    localparam int          TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage req/ack sequencer with pipeline stall, misalignment check and bus timeout
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_memread,
    input  logic        MEM_memwrite,
    input  logic [31:0] MEM_aluout,
    input  logic [31:0] MEM_regout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        wb_kill,
    output logic        addr_err,
    output logic        bus_err
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUSY = ST_BUSY;
    localparam logic [1:0] DONE = ST_DONE;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    logic [1:0] state;
    logic [7:0] cnt;
    logic       op, mis, in_idle, in_busy, in_done, tmo;
    assign op      = MEM_memread | MEM_memwrite;
    assign mis     = op & ((MEM_aluout & ALIGN_MASK) != '0);
    assign in_idle = state == IDLE;
    assign in_busy = state == BUSY;
    assign in_done = state == DONE;
    // an ack on the threshold cycle takes priority over the timeout
    assign tmo     = !dmem_ack && cnt == LAST;
    assign dmem_we    = in_busy & MEM_memwrite;
    assign dmem_addr  = MEM_aluout;
    assign dmem_wdata = MEM_regout;
    assign mem_stall  = rst_n & ((in_idle & op & !mis) | in_busy);
    assign wb_kill    = rst_n & ((in_idle & mis) | (in_done & bus_err));
    assign addr_err   = rst_n & in_idle & mis;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            load_data <= '0;
            bus_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (op && !mis) begin
                    state    <= BUSY;
                    dmem_req <= 1'b1;
                    cnt      <= '0;
                end
                BUSY: if (dmem_ack) begin
                    if (MEM_memread && !MEM_memwrite) load_data <= dmem_rdata;
                    dmem_req <= 1'b0;
                    state    <= DONE;
                end else if (tmo) begin
                    dmem_req  <= 1'b0;
                    load_data <= '0;
                    bus_err   <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: begin
                    state   <= IDLE;
                    bus_err <= 1'b0;
                end
            endcase
        end
    end
endmodule
